// File: rtl/banked_regfile.sv
// banked_regfile: four-bank register file with one write port, two registered read ports and a bank-clear sequencer
// Ports: clk, rst (sync, active-high); bank selects the bank for reads/writes/clear;
//        we/waddr/wdata write port; raddr_a/raddr_b -> rdata_a/rdata_b (1-cycle latency);
//        bank_clr pulse zeroes bank `bank` one register per cycle while busy is high.
// Optional: define BANKED_REGFILE_WRITE_BYPASS_EN to forward an accepted write to a same-address read.
module banked_regfile #(
    parameter int DW = 8,
    parameter int AW = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    bank,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr_a,
    input  logic [AW-1:0] raddr_b,
    input  logic          bank_clr,
    output logic [DW-1:0] rdata_a,
    output logic [DW-1:0] rdata_b,
    output logic          busy
);
    localparam int NR = 1 << AW;
    typedef enum logic {IDLE, CLEAR} state_t;
    state_t        state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [1:0]    clr_bank_q, clr_bank_d;
    logic [DW-1:0] mem_q [4][NR];
    logic [DW-1:0] rdata_a_q, rdata_a_d, rdata_b_q, rdata_b_d;
    logic          wr_ok;
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        clr_bank_d = clr_bank_q;
        wr_ok      = 1'b0;
        if (state_q == IDLE) begin
            if (bank_clr) begin
                state_d    = CLEAR;
                cnt_d      = '0;
                clr_bank_d = bank;
            end else begin
                wr_ok = we;
            end
        end else begin
            cnt_d   = cnt_q + AW'(1);
            state_d = &cnt_q ? IDLE : CLEAR;
        end
    end
    always_comb begin
`ifdef BANKED_REGFILE_WRITE_BYPASS_EN
        rdata_a_d = (wr_ok && raddr_a == waddr) ? wdata : mem_q[bank][raddr_a];
        rdata_b_d = (wr_ok && raddr_b == waddr) ? wdata : mem_q[bank][raddr_b];
`else
        rdata_a_d = mem_q[bank][raddr_a];
        rdata_b_d = mem_q[bank][raddr_b];
`endif
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            clr_bank_q <= '0;
            rdata_a_q  <= '0;
            rdata_b_q  <= '0;
            for (int b = 0; b < 4; b++)
                for (int r = 0; r < NR; r++)
                    mem_q[b][r] <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            clr_bank_q <= clr_bank_d;
            rdata_a_q  <= rdata_a_d;
            rdata_b_q  <= rdata_b_d;
            // writes are only accepted in IDLE, so they never collide with a clear write
            if (wr_ok)
                mem_q[bank][waddr] <= wdata;
            if (state_q == CLEAR)
                mem_q[clr_bank_q][cnt_q] <= '0;
        end
    end
    assign rdata_a = rdata_a_q;
    assign rdata_b = rdata_b_q;
    assign busy    = (state_q == CLEAR);
endmodule

// File: tb/tb_banked_regfile.sv
// tb_banked_regfile: scoreboard bench for banked_regfile; driver queues expectations, monitor checks after each edge
module tb_banked_regfile;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] bank = '0;
    logic       we = 1'b0;
    logic [2:0] waddr = '0;
    logic [7:0] wdata = '0;
    logic [2:0] raddr_a = '0;
    logic [2:0] raddr_b = '0;
    logic       bank_clr = 1'b0;
    logic [7:0] rdata_a, rdata_b;
    logic       busy;
    int total = 0;
    int bad = 0;
    logic chk_a = 0, chk_b = 0, chk_z = 0;
    logic pa = 0, pb = 0, pz = 0;
    string      qa_n[$], qb_n[$], qz_n[$];
    logic [7:0] qa_v[$], qb_v[$];
    logic       qz_v[$];

    banked_regfile #(.DW(8), .AW(3)) dut (
        .clk(clk), .rst(rst), .bank(bank), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr_a(raddr_a), .raddr_b(raddr_b), .bank_clr(bank_clr),
        .rdata_a(rdata_a), .rdata_b(rdata_b), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        pa <= chk_a;
        pb <= chk_b;
        pz <= chk_z;
    end

    always @(negedge clk) begin
        if (pa) begin
            total++;
            if (qa_n.size() == 0) begin
                bad++;
                $display("FAIL port_a underflow: got %h with nothing expected", rdata_a);
            end else begin
                string n;
                logic [7:0] e;
                n = qa_n.pop_front();
                e = qa_v.pop_front();
                if (rdata_a !== e) begin
                    bad++;
                    $display("FAIL %s: rdata_a=%h want %h", n, rdata_a, e);
                end
            end
        end
        if (pb) begin
            total++;
            if (qb_n.size() == 0) begin
                bad++;
                $display("FAIL port_b underflow: got %h with nothing expected", rdata_b);
            end else begin
                string n;
                logic [7:0] e;
                n = qb_n.pop_front();
                e = qb_v.pop_front();
                if (rdata_b !== e) begin
                    bad++;
                    $display("FAIL %s: rdata_b=%h want %h", n, rdata_b, e);
                end
            end
        end
        if (pz) begin
            total++;
            if (qz_n.size() == 0) begin
                bad++;
                $display("FAIL busy underflow: got %b with nothing expected", busy);
            end else begin
                string n;
                logic e;
                n = qz_n.pop_front();
                e = qz_v.pop_front();
                if (busy !== e) begin
                    bad++;
                    $display("FAIL %s: busy=%b want %b", n, busy, e);
                end
            end
        end
    end

    task automatic xa(input string n, input logic [7:0] e);
        chk_a = 1'b1;
        qa_n.push_back(n);
        qa_v.push_back(e);
    endtask

    task automatic xb(input string n, input logic [7:0] e);
        chk_b = 1'b1;
        qb_n.push_back(n);
        qb_v.push_back(e);
    endtask

    task automatic xz(input string n, input logic e);
        chk_z = 1'b1;
        qz_n.push_back(n);
        qz_v.push_back(e);
    endtask

    task automatic nx();
        @(posedge clk);
        #1;
        we = 1'b0;
        bank_clr = 1'b0;
        chk_a = 1'b0;
        chk_b = 1'b0;
        chk_z = 1'b0;
    endtask

    task automatic wr(input logic [1:0] b, input logic [2:0] a, input logic [7:0] d);
        bank = b;
        we = 1'b1;
        waddr = a;
        wdata = d;
        nx();
    endtask

    task automatic wait_idle(input string n);
        int k = 0;
        while (busy && k < 40) begin
            nx();
            k++;
        end
        total++;
        if (busy) begin
            bad++;
            $display("FAIL %s: busy=%b want 0 within 40 cycles", n, busy);
        end
    endtask

    initial begin
        // reset
        xa("rst_a", 8'h00);
        xb("rst_b", 8'h00);
        xz("rst_busy", 1'b0);
        nx();
        nx();
        rst = 1'b0;
        bank = 2'd2;
        raddr_a = 3'd5;
        xa("rst_read_b2a5", 8'h00);
        xz("rst_read_busy", 1'b0);
        nx();
        // bank isolation
        wr(2'd0, 3'd3, 8'hA5);
        wr(2'd1, 3'd3, 8'h5A);
        bank = 2'd0;
        raddr_a = 3'd3;
        xa("iso_b0a3", 8'hA5);
        nx();
        bank = 2'd1;
        raddr_b = 3'd3;
        xb("iso_b1a3", 8'h5A);
        nx();
        // clear sequence on bank 2
        for (int i = 0; i < 8; i++)
            wr(2'd2, 3'(i), 8'h11 + 8'(i));
        wr(2'd0, 3'd7, 8'hC7);
        bank = 2'd2;
        raddr_a = 3'd7;
        xa("fill_b2a7", 8'h18);
        nx();
        bank = 2'd2;
        bank_clr = 1'b1;
        xz("clr_busy0", 1'b1);
        nx();
        for (int i = 1; i <= 8; i++) begin
            bank = (i <= 2) ? 2'd2 : 2'd0;
            raddr_a = 3'd0;
            raddr_b = 3'd7;
            if (i == 1) xa("clr_same_cycle_old", 8'h11);
            else if (i == 2) xa("clr_next_zero", 8'h00);
            else xb("clr_bank0_live", 8'hC7);
            bank_clr = (i == 3);
            xz("clr_busy", i < 8);
            nx();
        end
        for (int i = 0; i < 8; i++) begin
            bank = 2'd2;
            raddr_a = 3'(i);
            xa("clr_b2_zero", 8'h00);
            nx();
        end
        bank = 2'd0;
        raddr_a = 3'd3;
        raddr_b = 3'd7;
        xa("clr_b0a3_kept", 8'hA5);
        xb("clr_b0a7_kept", 8'hC7);
        nx();
        // write during busy is dropped
        bank = 2'd1;
        bank_clr = 1'b1;
        nx();
        nx();
        wr(2'd3, 3'd0, 8'hFF);
        wait_idle("busy_fall_1");
        bank = 2'd3;
        raddr_a = 3'd0;
        xa("busy_write_dropped", 8'h00);
        nx();
        bank = 2'd1;
        raddr_b = 3'd3;
        xb("b1_cleared", 8'h00);
        nx();
        // same-cycle write/read
        wr(2'd0, 3'd4, 8'h33);
        bank = 2'd0;
        we = 1'b1;
        waddr = 3'd4;
        wdata = 8'h77;
        raddr_a = 3'd4;
        raddr_b = 3'd4;
`ifdef BANKED_REGFILE_WRITE_BYPASS_EN
        xa("rw_same_a", 8'h77);
        xb("rw_same_b", 8'h77);
`else
        xa("rw_same_a", 8'h33);
        xb("rw_same_b", 8'h33);
`endif
        nx();
        xa("rw_next_a", 8'h77);
        nx();
        // reset mid-clear
        bank = 2'd0;
        bank_clr = 1'b1;
        nx();
        nx();
        nx();
        nx();
        rst = 1'b1;
        xz("rst_mid_busy", 1'b0);
        nx();
        rst = 1'b0;
        for (int b = 0; b < 4; b++)
            for (int a = 0; a < 8; a++) begin
                bank = 2'(b);
                raddr_a = 3'(a);
                raddr_b = 3'(7 - a);
                xa("rst_all_zero_a", 8'h00);
                xb("rst_all_zero_b", 8'h00);
                nx();
            end
        bank = 2'd1;
        bank_clr = 1'b1;
        xz("reclear_accepted", 1'b1);
        nx();
        wait_idle("busy_fall_2");
        nx();
        nx();
        total++;
        if (qa_n.size() + qb_n.size() + qz_n.size() != 0) begin
            bad++;
            $display("FAIL leftover: pending=%0d want 0", qa_n.size() + qb_n.size() + qz_n.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
